// File: rtl/stack_pkg.sv
// Shared constants for the stack controller: op codes, FSM encoding and the
// default stack window, which the external SP register preset must match.
package stack_pkg;

    localparam logic [15:0] DEF_STACK_TOP    = 16'hF3FF;
    localparam logic [15:0] DEF_STACK_BOTTOM = 16'hF000;
    // Block-RAM read latency; the WAIT state assumes exactly one cycle.
    localparam int          RD_LAT           = 1;

    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_PEEK = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_WAIT,
        ST_DONE,
        ST_ERR
    } state_t;

endpackage

// File: rtl/stack_ctrl.sv
// Stack op sequencer: drives the external SP register and a 1-cycle-latency RAM.
// Latency accept->DONE: PUSH/LOAD_SP 2, POP/PEEK 3, error 1; OP_READY only in IDLE.
module stack_ctrl
    import stack_pkg::*;
#(
    parameter logic [15:0] STACK_TOP    = DEF_STACK_TOP,
    parameter logic [15:0] STACK_BOTTOM = DEF_STACK_BOTTOM
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        OP_VALID,
    output logic        OP_READY,
    input  logic [1:0]  OP_CODE,
    input  logic [15:0] OP_DATA,
    output logic        DONE,
    output logic [15:0] RESULT,
    output logic        ERR_OVF,
    output logic        ERR_UNF,
    input  logic [15:0] SP_IN,
    output logic        SP_CE,
    output logic [15:0] NEW_SP,
    output logic        SP_PRESET,
    output logic [15:0] MEM_ADDR,
    output logic [15:0] MEM_WDATA,
    output logic        MEM_WE,
    output logic        MEM_RE,
    input  logic [15:0] MEM_RDATA
);

    localparam logic [15:0] SP_FULL = STACK_BOTTOM - 16'd1;

    state_t      state_q, state_d;
    logic [1:0]  op_q;
    logic [15:0] data_q;
    logic [15:0] result_q;

    logic accept;
    assign accept = (state_q == ST_IDLE) && OP_VALID;

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_PUSH;
            data_q   <= 16'h0000;
            result_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q   <= OP_CODE;
                data_q <= OP_DATA;
            end
            if (state_q == ST_WAIT) begin
                result_q <= MEM_RDATA;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        SP_CE     = 1'b0;
        NEW_SP    = 16'h0000;
        MEM_ADDR  = 16'h0000;
        MEM_WDATA = 16'h0000;
        MEM_WE    = 1'b0;
        MEM_RE    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (OP_VALID) begin
                    case (OP_CODE)
                        OP_PUSH: state_d = (SP_IN == SP_FULL) ? ST_ERR : ST_WRITE;
                        OP_POP,
                        OP_PEEK: state_d = (SP_IN == STACK_TOP) ? ST_ERR : ST_READ;
                        default: state_d = (OP_DATA < SP_FULL || OP_DATA > STACK_TOP)
                                           ? ST_ERR : ST_WRITE;
                    endcase
                end
            end
            ST_WRITE: begin
                SP_CE   = 1'b1;
                state_d = ST_DONE;
                if (op_q == OP_PUSH) begin
                    MEM_ADDR  = SP_IN;
                    MEM_WDATA = data_q;
                    MEM_WE    = 1'b1;
                    NEW_SP    = SP_IN - 16'd1;
                end else begin
                    NEW_SP = data_q;
                end
            end
            ST_READ: begin
                // SP points at the next free word, so the top item sits one above.
                MEM_ADDR = SP_IN + 16'd1;
                MEM_RE   = 1'b1;
                state_d  = ST_WAIT;
                if (op_q == OP_POP) begin
                    SP_CE  = 1'b1;
                    NEW_SP = SP_IN + 16'd1;
                end
            end
            ST_WAIT: state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // The state register only clears at the reset edge, so mask strobes meanwhile.
        if (!RESET_N) begin
            SP_CE  = 1'b0;
            MEM_WE = 1'b0;
            MEM_RE = 1'b0;
        end
    end

    assign OP_READY  = (state_q == ST_IDLE);
    assign DONE      = (state_q == ST_DONE) || (state_q == ST_ERR);
    assign ERR_OVF   = (state_q == ST_ERR) && ((op_q == OP_PUSH) || (op_q == OP_LOAD));
    assign ERR_UNF   = (state_q == ST_ERR) && ((op_q == OP_POP) || (op_q == OP_PEEK));
    assign RESULT    = result_q;
    assign SP_PRESET = !RESET_N;

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl with an SP register and 1-cycle RAM around it; directed
// table, reset/back-to-back sequences, then random ops against a stack model.
module tb_stack_ctrl;
    import stack_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        OP_VALID;
    logic        OP_READY;
    logic [1:0]  OP_CODE;
    logic [15:0] OP_DATA;
    logic        DONE;
    logic [15:0] RESULT;
    logic        ERR_OVF;
    logic        ERR_UNF;
    logic [15:0] SP_IN;
    logic        SP_CE;
    logic [15:0] NEW_SP;
    logic        SP_PRESET;
    logic [15:0] MEM_ADDR;
    logic [15:0] MEM_WDATA;
    logic        MEM_WE;
    logic        MEM_RE;
    logic [15:0] MEM_RDATA;

    always #5 CLK = ~CLK;

    stack_ctrl dut (
        .CLK(CLK), .RESET_N(RESET_N), .OP_VALID(OP_VALID), .OP_READY(OP_READY),
        .OP_CODE(OP_CODE), .OP_DATA(OP_DATA), .DONE(DONE), .RESULT(RESULT),
        .ERR_OVF(ERR_OVF), .ERR_UNF(ERR_UNF), .SP_IN(SP_IN), .SP_CE(SP_CE),
        .NEW_SP(NEW_SP), .SP_PRESET(SP_PRESET), .MEM_ADDR(MEM_ADDR),
        .MEM_WDATA(MEM_WDATA), .MEM_WE(MEM_WE), .MEM_RE(MEM_RE), .MEM_RDATA(MEM_RDATA)
    );

    logic [15:0] sp_reg;
    logic [15:0] ram [int];

    always @(posedge CLK) begin
        if (SP_PRESET)  sp_reg <= DEF_STACK_TOP;
        else if (SP_CE) sp_reg <= NEW_SP;
    end
    assign SP_IN = sp_reg;

    always @(posedge CLK) begin
        if (MEM_WE) ram[int'(MEM_ADDR)] = MEM_WDATA;
        if (MEM_RE) MEM_RDATA <= ram.exists(int'(MEM_ADDR)) ? ram[int'(MEM_ADDR)] : 16'h0000;
    end

    int n_vec = 0;
    int n_mis = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference model: SP as a plain integer, stack memory as a sparse map.
    int          m_sp = int'(DEF_STACK_TOP);
    logic [15:0] m_mem [int];
    logic [15:0] m_res = 16'h0000;

    task automatic model(input logic [1:0] op, input logic [15:0] d, output int lat,
                         output logic ovf, output logic unf, output int nwe, output int nre);
        ovf = 1'b0; unf = 1'b0; nwe = 0; nre = 0;
        case (op)
            OP_PUSH: begin
                if (m_sp == int'(DEF_STACK_BOTTOM) - 1) ovf = 1'b1;
                else begin m_mem[m_sp] = d; m_sp = m_sp - 1; nwe = 1; end
            end
            OP_POP, OP_PEEK: begin
                if (m_sp == int'(DEF_STACK_TOP)) unf = 1'b1;
                else begin
                    m_res = m_mem.exists(m_sp + 1) ? m_mem[m_sp + 1] : 16'h0000;
                    if (op == OP_POP) m_sp = m_sp + 1;
                    nre = 1;
                end
            end
            default: begin
                if (int'(d) < int'(DEF_STACK_BOTTOM) - 1 || int'(d) > int'(DEF_STACK_TOP)) ovf = 1'b1;
                else m_sp = int'(d);
            end
        endcase
        lat = (ovf || unf) ? 1 : ((op == OP_POP || op == OP_PEEK) ? 3 : 2);
    endtask

    // Issue one op from IDLE; returns cycles from accept edge to DONE and strobe counts.
    task automatic run_op(input logic [1:0] op, input logic [15:0] d, output int lat,
                          output logic ovf, output logic unf, output logic [15:0] res,
                          output int nwe, output int nre);
        int g = 0;
        while (!OP_READY && g < 20) begin @(negedge CLK); g++; end
        if (!OP_READY) chk("ready_timeout", 32'(OP_READY), 32'd1);
        OP_VALID = 1'b1; OP_CODE = op; OP_DATA = d;
        @(posedge CLK);
        @(negedge CLK);
        OP_VALID = 1'b0;
        lat = 1; nwe = 0; nre = 0;
        while (1) begin
            nwe += int'(MEM_WE);
            nre += int'(MEM_RE);
            if (DONE || lat >= 10) break;
            @(negedge CLK);
            lat++;
        end
        ovf = ERR_OVF; unf = ERR_UNF; res = RESULT;
        @(negedge CLK);
    endtask

    task automatic run_and_check(input string tag, input logic [1:0] op, input logic [15:0] d);
        int   lat, elat, nwe, enwe, nre, enre;
        logic ovf, eovf, unf, eunf;
        logic [15:0] res;
        model(op, d, elat, eovf, eunf, enwe, enre);
        run_op(op, d, lat, ovf, unf, res, nwe, nre);
        chk({tag, "_lat"}, 32'(lat), 32'(elat));
        chk({tag, "_ovf"}, 32'(ovf), 32'(eovf));
        chk({tag, "_unf"}, 32'(unf), 32'(eunf));
        chk({tag, "_res"}, 32'(res), 32'(m_res));
        chk({tag, "_sp"},  32'(sp_reg), 32'(m_sp));
        chk({tag, "_we"},  32'(nwe), 32'(enwe));
        chk({tag, "_re"},  32'(nre), 32'(enre));
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [15:0] d;
        int          lat;
        logic        ovf;
        logic        unf;
        logic [15:0] res;
        logic [15:0] sp;
    } vec_t;

    vec_t tbl [11];

    initial begin
        int   lat, nwe, nre, mlat, mnwe, mnre;
        logic ovf, unf, movf, munf;
        logic [15:0] res, rd;
        int   dpos [$];

        tbl[0]  = '{OP_PUSH, 16'hABCD, 2, 1'b0, 1'b0, 16'h0000, 16'hF3FE};
        tbl[1]  = '{OP_PUSH, 16'h1234, 2, 1'b0, 1'b0, 16'h0000, 16'hF3FD};
        tbl[2]  = '{OP_PEEK, 16'h0000, 3, 1'b0, 1'b0, 16'h1234, 16'hF3FD};
        tbl[3]  = '{OP_POP,  16'h0000, 3, 1'b0, 1'b0, 16'h1234, 16'hF3FE};
        tbl[4]  = '{OP_POP,  16'h0000, 3, 1'b0, 1'b0, 16'hABCD, 16'hF3FF};
        tbl[5]  = '{OP_POP,  16'h0000, 1, 1'b0, 1'b1, 16'hABCD, 16'hF3FF};
        tbl[6]  = '{OP_LOAD, 16'hEFFF, 2, 1'b0, 1'b0, 16'hABCD, 16'hEFFF};
        tbl[7]  = '{OP_PUSH, 16'h5555, 1, 1'b1, 1'b0, 16'hABCD, 16'hEFFF};
        tbl[8]  = '{OP_LOAD, 16'hF400, 1, 1'b1, 1'b0, 16'hABCD, 16'hEFFF};
        tbl[9]  = '{OP_LOAD, 16'hF3FF, 2, 1'b0, 1'b0, 16'hABCD, 16'hF3FF};
        tbl[10] = '{OP_PEEK, 16'h0000, 1, 1'b0, 1'b1, 16'hABCD, 16'hF3FF};

        RESET_N = 1'b0; OP_VALID = 1'b0; OP_CODE = OP_PUSH; OP_DATA = 16'h0000;
        @(negedge CLK);
        chk("rst_preset", 32'(SP_PRESET), 32'd1);
        chk("rst_strobes", {29'd0, SP_CE, MEM_WE, MEM_RE}, 32'd0);
        @(negedge CLK);
        chk("rst_sp", 32'(sp_reg), 32'hF3FF);
        RESET_N = 1'b1;
        @(negedge CLK);
        chk("idle_ready", 32'(OP_READY), 32'd1);
        chk("idle_done", 32'(DONE), 32'd0);
        chk("idle_result", 32'(RESULT), 32'd0);
        chk("idle_preset", 32'(SP_PRESET), 32'd0);

        for (int i = 0; i < 11; i++) begin
            model(tbl[i].op, tbl[i].d, mlat, movf, munf, mnwe, mnre);
            run_op(tbl[i].op, tbl[i].d, lat, ovf, unf, res, nwe, nre);
            chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
            chk($sformatf("tbl%0d_ovf", i), 32'(ovf), 32'(tbl[i].ovf));
            chk($sformatf("tbl%0d_unf", i), 32'(unf), 32'(tbl[i].unf));
            chk($sformatf("tbl%0d_res", i), 32'(res), 32'(tbl[i].res));
            chk($sformatf("tbl%0d_sp", i), 32'(sp_reg), 32'(tbl[i].sp));
            chk($sformatf("tbl%0d_we", i), 32'(nwe),
                32'(tbl[i].op == OP_PUSH && !tbl[i].ovf));
            chk($sformatf("tbl%0d_re", i), 32'(nre),
                32'((tbl[i].op == OP_POP || tbl[i].op == OP_PEEK) && !tbl[i].unf));
        end
        rd = ram.exists(32'hF3FF) ? ram[32'hF3FF] : 16'h0000;
        chk("ram_F3FF", 32'(rd), 32'hABCD);
        rd = ram.exists(32'hF3FE) ? ram[32'hF3FE] : 16'h0000;
        chk("ram_F3FE", 32'(rd), 32'h1234);

        // Reset during the WAIT cycle of a POP aborts it with no DONE.
        run_and_check("pre_a", OP_PUSH, 16'h0A0A);
        run_and_check("pre_b", OP_PUSH, 16'h0B0B);
        OP_VALID = 1'b1; OP_CODE = OP_POP;
        @(posedge CLK);
        @(negedge CLK);
        OP_VALID = 1'b0;
        chk("abort_read_re", 32'(MEM_RE), 32'd1);
        @(negedge CLK);
        RESET_N = 1'b0;
        #1;
        chk("abort_wait_done", 32'(DONE), 32'd0);
        chk("abort_wait_preset", 32'(SP_PRESET), 32'd1);
        @(negedge CLK);
        chk("abort_done", 32'(DONE), 32'd0);
        chk("abort_ready", 32'(OP_READY), 32'd1);
        chk("abort_sp", 32'(sp_reg), 32'hF3FF);
        chk("abort_result", 32'(RESULT), 32'd0);
        RESET_N = 1'b1;
        m_sp = int'(DEF_STACK_TOP); m_res = 16'h0000;
        @(negedge CLK);
        run_and_check("post_rst_push", OP_PUSH, 16'h4242);

        // OP_VALID held high: re-accepted in the IDLE cycle after DONE.
        model(OP_PUSH, 16'h7777, mlat, movf, munf, mnwe, mnre);
        model(OP_PUSH, 16'h7777, mlat, movf, munf, mnwe, mnre);
        OP_VALID = 1'b1; OP_CODE = OP_PUSH; OP_DATA = 16'h7777;
        @(posedge CLK);
        for (int i = 1; i <= 6; i++) begin
            @(negedge CLK);
            if (DONE) dpos.push_back(i);
        end
        OP_VALID = 1'b0;
        chk("b2b_count", 32'(dpos.size()), 32'd2);
        if (dpos.size() == 2) begin
            chk("b2b_first", 32'(dpos[0]), 32'd2);
            chk("b2b_second", 32'(dpos[1]), 32'd5);
        end
        chk("b2b_sp", 32'(sp_reg), 32'(m_sp));
        @(negedge CLK);

        for (int i = 0; i < 300; i++) begin
            logic [1:0]  op;
            logic [15:0] d;
            op = 2'($urandom_range(0, 3));
            d  = 16'($urandom);
            if (op == OP_LOAD) begin
                case ($urandom_range(0, 5))
                    0: d = DEF_STACK_BOTTOM - 16'd1;
                    1: d = DEF_STACK_TOP;
                    2: d = DEF_STACK_TOP + 16'd1;
                    3: d = DEF_STACK_BOTTOM - 16'd2;
                    4: d = 16'($urandom_range(32'hEFFF, 32'hF3FF));
                    default: d = DEF_STACK_BOTTOM + 16'd2;
                endcase
            end
            run_and_check($sformatf("rnd%0d", i), op, d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
